// File: rtl/window_pkg.sv
// window_pkg: shared state encoding, coefficient-source codes and default
// geometry for the two-channel windowing datapath.
package window_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, STOPPING} state_t;
  localparam logic SEL_ROM = 1'b0;
  localparam logic SEL_RAM = 1'b1;
  localparam int DEF_FRAME_LEN = 256;
  localparam int DEF_LAST_LAT = 8;
endpackage

// File: rtl/pulse_delay_line.sv
// pulse_delay_line: fixed-depth single-bit shift register used to align
// strobes with downstream pipeline latency.
module pulse_delay_line #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= (sr << 1) | DEPTH'(din);
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/window_frame_sequencer.sv
// window_frame_sequencer: per-sample window coefficient addressing with
// frame-boundary ROM/RAM source switching, frame counting and frame_last.
module window_frame_sequencer
  import window_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ADDR_W    = 8,
  parameter int LAST_LAT  = DEF_LAST_LAT,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              sample_valid,
  input  logic              ram_sel_req,
  input  logic              rom_sel_req,
  input  logic              ram_load_busy,
  output logic              rom_rd_en,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              coef_mux_sel,
  output logic              frame_last,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              sel_blocked,
  output logic              busy
);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              active_sel, pending_sel, pend_nxt, new_sel;
  logic              accept, last_addr, boundary, arm, blocked_now;

  assign busy        = state != IDLE;
  assign accept      = sample_valid & busy;
  assign last_addr   = addr == ADDR_W'(FRAME_LEN - 1);
  assign boundary    = accept & last_addr;
  assign arm         = start & (state == IDLE);
  // a request arriving on the boundary cycle already applies to the next frame
  assign pend_nxt    = ram_sel_req ? SEL_RAM : rom_sel_req ? SEL_ROM : pending_sel;
  assign blocked_now = pend_nxt & ram_load_busy;
  assign new_sel     = pend_nxt ? (ram_load_busy ? active_sel : SEL_RAM) : SEL_ROM;
  assign rom_rd_en   = accept & ~active_sel;
  assign ram_rd_en   = accept & active_sel;
  assign coef_addr   = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= '0;
      active_sel   <= SEL_ROM;
      pending_sel  <= SEL_ROM;
      coef_mux_sel <= 1'b0;
      frame_cnt    <= '0;
      sel_blocked  <= 1'b0;
    end else begin
      state        <= arm ? ACTIVE :
                      (state == ACTIVE && stop) ? STOPPING :
                      (state == STOPPING && boundary) ? IDLE : state;
      pending_sel  <= pend_nxt;
      coef_mux_sel <= active_sel;
      if (arm || boundary) active_sel <= new_sel;
      if (boundary) frame_cnt <= frame_cnt + CNT_W'(1);
      if (arm) addr <= '0;
      else if (accept) addr <= last_addr ? '0 : addr + ADDR_W'(1);
      if (arm) sel_blocked <= blocked_now;
      else if (boundary && blocked_now) sel_blocked <= 1'b1;
    end
  end

  pulse_delay_line #(.DEPTH(LAST_LAT)) u_last_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (boundary),
    .dout (frame_last)
  );
endmodule
